// File: rtl/fsm_serial_tx.sv
// rtl/fsm_serial_tx.sv - serial frame transmitter: preamble, MSB-first data, even parity, idle gap
module fsm_serial_tx #(
    parameter int                 DATA_W  = 8,
    parameter int                 PRE_LEN = 2,
    parameter logic [PRE_LEN-1:0] PRE_PAT = 2'b10,
    parameter int                 GAP_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sout,
    output logic              sout_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_MAX = (DATA_W > PRE_LEN)
                           ? ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN)
                           : ((PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_n;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_n;
    logic                r_parity;
    logic                w_parity_n;
    logic                r_sout;
    logic                w_sout_n;
    logic                r_sout_en;
    logic                w_sout_en_n;
    logic                r_busy;
    logic                w_busy_n;
    logic                r_frame_done;
    logic                w_frame_done_n;
    logic                w_last;
    logic [PRE_LEN-1:0]  w_pre_sel;

    // The counter holds the remaining cycles in the current state minus one.
    assign w_last     = (r_cnt == '0);
    assign tx_ready   = (r_state == S_IDLE) && !rst;
    assign sout       = r_sout;
    assign sout_en    = r_sout_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_shift_n  = r_shift;
        w_parity_n = r_parity;

        case (r_state)
            S_IDLE: begin
                if (tx_valid && !rst) begin
                    w_state_n  = S_PRE;
                    w_cnt_n    = CNT_W'(PRE_LEN - 1);
                    w_shift_n  = tx_data;
                    w_parity_n = ^tx_data;
                end
            end
            S_PRE: begin
                if (w_last) begin
                    w_state_n = S_DATA;
                    w_cnt_n   = CNT_W'(DATA_W - 1);
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_state_n = S_PARITY;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n   = r_cnt - CNT_W'(1);
                    w_shift_n = r_shift << 1;
                end
            end
            S_PARITY: begin
                if (GAP_LEN > 0) begin
                    w_state_n = S_GAP;
                    w_cnt_n   = CNT_W'(GAP_LEN - 1);
                end else begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end
            end
            S_GAP: begin
                if (w_last) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered.
        w_pre_sel       = PRE_PAT >> w_cnt_n;
        w_sout_n        = 1'b0;
        w_sout_en_n     = 1'b0;
        w_busy_n        = 1'b0;
        w_frame_done_n  = 1'b0;
        case (w_state_n)
            S_PRE: begin
                w_sout_n    = w_pre_sel[0];
                w_sout_en_n = 1'b1;
                w_busy_n    = 1'b1;
            end
            S_DATA: begin
                w_sout_n    = w_shift_n[DATA_W-1];
                w_sout_en_n = 1'b1;
                w_busy_n    = 1'b1;
            end
            S_PARITY: begin
                w_sout_n       = w_parity_n;
                w_sout_en_n    = 1'b1;
                w_busy_n       = 1'b1;
                w_frame_done_n = 1'b1;
            end
            S_GAP: begin
                w_busy_n = 1'b1;
            end
            default: begin
                w_busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_sout       <= 1'b0;
            r_sout_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_shift      <= w_shift_n;
            r_parity     <= w_parity_n;
            r_sout       <= w_sout_n;
            r_sout_en    <= w_sout_en_n;
            r_busy       <= w_busy_n;
            r_frame_done <= w_frame_done_n;
        end
    end

endmodule

// File: tb/tb_fsm_serial_tx.sv
// tb/tb_fsm_serial_tx.sv - scoreboard bench for fsm_serial_tx, default and minimal parameter sets
module tb_fsm_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0;
    logic       v0, r0, s0, e0, b0, f0;
    logic [0:0] d1;
    logic       v1, r1, s1, e1, b1, f1;

    always #5 clk = ~clk;

    fsm_serial_tx dut0 (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
        .sout(s0), .sout_en(e0), .busy(b0), .frame_done(f0)
    );

    fsm_serial_tx #(.DATA_W(1), .PRE_LEN(1), .PRE_PAT(1'b1), .GAP_LEN(0)) dut1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
        .sout(s1), .sout_en(e1), .busy(b1), .frame_done(f1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tmo = 0;
    int tmo_seen = 0;
    int remain[2]     = '{0, 0};
    int acc_cnt[2]    = '{0, 0};
    int acc_cyc[2]    = '{0, 0};
    int last_gap[2]   = '{0, 0};
    int seen_acc[2]   = '{0, 0};
    int exp_period[2] = '{0, 0};
    logic fin_req = 1'b0;
    logic fin_done = 1'b0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    function automatic int pre_len(input int k);   return (k == 0) ? 2 : 1; endfunction
    function automatic int data_w(input int k);    return (k == 0) ? 8 : 1; endfunction
    function automatic int gap_len(input int k);   return (k == 0) ? 1 : 0; endfunction
    function automatic int frame_len(input int k); return pre_len(k) + data_w(k) + 1; endfunction
    function automatic int busy_len(input int k);  return frame_len(k) + gap_len(k); endfunction
    function automatic logic pre_bit(input int k, input int i);
        return (k == 0) ? (i == 0) : 1'b1;
    endfunction

    task automatic push_exp(input int k, input logic [1:0] x);
        if (k == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Reference model: a frame is a list of bits pushed at accept time.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            logic        vv;
            logic [31:0] dd;
            vv = (k == 0) ? v0 : v1;
            dd = (k == 0) ? {24'b0, d0} : {31'b0, d1};
            if (rst) begin
                remain[k] = 0;
                if (k == 0) q0.delete();
                else        q1.delete();
            end else if (remain[k] > 0) begin
                remain[k]--;
            end else if (vv) begin
                remain[k] = busy_len(k);
                if (acc_cnt[k] > 0) last_gap[k] = cyc - acc_cyc[k];
                acc_cyc[k] = cyc;
                acc_cnt[k]++;
                for (int i = 0; i < pre_len(k); i++) push_exp(k, {1'b0, pre_bit(k, i)});
                for (int i = data_w(k) - 1; i >= 0; i--) push_exp(k, {1'b0, dd[i]});
                push_exp(k, {1'b1, ($countones(dd) % 2) == 1});
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", name, k, cyc, got, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                logic s, e, b, f, r;
                logic [1:0] x;
                int pos;
                if (k == 0) begin s = s0; e = e0; b = b0; f = f0; r = r0; end
                else        begin s = s1; e = e1; b = b1; f = f1; r = r1; end
                pos = busy_len(k) - remain[k];
                chk("busy", k, {31'b0, b}, {31'b0, remain[k] > 0});
                chk("tx_ready", k, {31'b0, r}, {31'b0, (remain[k] == 0) && !rst});
                chk("sout_en", k, {31'b0, e}, {31'b0, (remain[k] > 0) && (pos < frame_len(k))});
                if (e === 1'b1) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        chk("unexpected_bit", k, 32'd1, 32'd0);
                    end else begin
                        x = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("sout", k, {31'b0, s}, {31'b0, x[0]});
                        chk("frame_done", k, {31'b0, f}, {31'b0, x[1]});
                    end
                end else begin
                    chk("sout_idle", k, {31'b0, s}, 32'd0);
                    chk("frame_done_idle", k, {31'b0, f}, 32'd0);
                end
                if (acc_cnt[k] != seen_acc[k]) begin
                    seen_acc[k] = acc_cnt[k];
                    if (exp_period[k] != 0) chk("accept_period", k, last_gap[k], exp_period[k]);
                end
            end
            if (tmo != tmo_seen) begin
                chk("handshake_timeout", 0, tmo, tmo_seen);
                tmo_seen = tmo;
            end
            if (fin_req && !fin_done) begin
                chk("leftover_bits", 0, q0.size(), 0);
                chk("leftover_bits", 1, q1.size(), 0);
                fin_done = 1'b1;
            end
        end
    end

    task automatic set_valid(input int k, input logic v);
        if (k == 0) v0 = v;
        else        v1 = v;
    endtask

    task automatic wait_acc(input int k, input int n0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt[k] != n0) return;
        end
        tmo++;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 60; i++) begin
            if (remain[k] == 0) return;
            @(posedge clk);
            #1;
        end
        tmo++;
    endtask

    task automatic send(input int k, input logic [7:0] data);
        int n0;
        n0 = acc_cnt[k];
        if (k == 0) d0 = data;
        else        d1 = data[0];
        set_valid(k, 1'b1);
        wait_acc(k, n0);
        set_valid(k, 1'b0);
        d0 = 8'($urandom);
        d1 = 1'($urandom);
    endtask

    initial begin
        int n;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h5A; d1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;

        send(0, 8'hA5); wait_idle(0);
        send(0, 8'h07); wait_idle(0);
        send(0, 8'h00); wait_idle(0);

        // Held valid: back-to-back frames, data toggled during the first.
        d0 = 8'h3C; v0 = 1'b1;
        n = acc_cnt[0];
        wait_acc(0, n);
        @(negedge clk); #1;
        exp_period[0] = 13;
        n = acc_cnt[0];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            d0 = 8'($urandom);
        end
        d0 = 8'hC3;
        wait_acc(0, n);
        d0 = 8'($urandom);
        wait_acc(0, n + 1);
        v0 = 1'b0;
        @(negedge clk); #1;
        exp_period[0] = 0;
        wait_idle(0);

        // Reset during data bit 4, then a clean frame.
        n = acc_cnt[0];
        d0 = 8'($urandom); v0 = 1'b1;
        wait_acc(0, n);
        v0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 8'hFF); wait_idle(0);

        // Minimal parameter set, held valid.
        d1 = 1'b1; v1 = 1'b1;
        n = acc_cnt[1];
        wait_acc(1, n);
        @(negedge clk); #1;
        exp_period[1] = 4;
        wait_acc(1, n + 1);
        wait_acc(1, n + 2);
        v1 = 1'b0;
        @(negedge clk); #1;
        exp_period[1] = 0;
        wait_idle(1);

        for (int it = 0; it < 40; it++) begin
            int k;
            k = int'($urandom_range(1));
            send(k, 8'($urandom));
            if ($urandom_range(9) == 0) begin
                repeat ($urandom_range(10)) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            if ($urandom_range(1) == 1) wait_idle(k);
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
        end
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(posedge clk);
        #1;
        fin_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!fin_done) begin
            $display("FAIL monitor_stalled fin_done=%0b expected=1", fin_done);
            $fatal(1, "monitor did not complete");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
